// File: rtl/mips_mem_pkg.sv
// Shared types and address-geometry helpers for the MEM-stage data cache.
package mips_mem_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_REFILL = 2'd1,
        S_WRITE  = 2'd2
    } state_e;

    function automatic int word_off_w(input int words_per_line);
        return $clog2(words_per_line);
    endfunction

    function automatic int offset_w(input int words_per_line);
        return 2 + $clog2(words_per_line);
    endfunction

    function automatic int index_w(input int lines);
        return $clog2(lines);
    endfunction

    function automatic int tag_w(input int addr_w, input int lines, input int words_per_line);
        return addr_w - offset_w(words_per_line) - index_w(lines);
    endfunction

endpackage

// File: rtl/dcache_line_store.sv
// Tag/valid/data arrays: one combinational read port, one word write port, valid clear/set.
module dcache_line_store
    import mips_mem_pkg::*;
#(
    parameter int LINES          = 16,
    parameter int WORDS_PER_LINE = 4,
    parameter int TAG_W          = 24,
    parameter int IDX_W          = 4,
    parameter int WOFF_W         = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [IDX_W-1:0]  i_rd_index,
    input  logic [WOFF_W-1:0] i_rd_word,
    output logic [TAG_W-1:0]  o_rd_tag,
    output logic              o_rd_valid,
    output logic [WORD_W-1:0] o_rd_data,
    input  logic              i_wr_en,
    input  logic [IDX_W-1:0]  i_wr_index,
    input  logic [WOFF_W-1:0] i_wr_word,
    input  logic [WORD_W-1:0] i_wr_data,
    input  logic              i_clr_en,
    input  logic [IDX_W-1:0]  i_clr_index,
    input  logic              i_set_en,
    input  logic [IDX_W-1:0]  i_set_index,
    input  logic [TAG_W-1:0]  i_set_tag
);

    logic [WORD_W-1:0] r_data [LINES*WORDS_PER_LINE];
    logic [TAG_W-1:0]  r_tag  [LINES];
    logic [LINES-1:0]  r_valid;

    // Data and tag arrays carry no reset; validity alone qualifies their contents.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_data[{i_wr_index, i_wr_word}] <= i_wr_data;
        end
        if (i_set_en) begin
            r_tag[i_set_index] <= i_set_tag;
        end
    end

    // Valid bits: cleared asynchronously, invalidated on miss, set when a refill completes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= '0;
        end else begin
            if (i_clr_en) begin
                r_valid[i_clr_index] <= 1'b0;
            end
            if (i_set_en) begin
                r_valid[i_set_index] <= 1'b1;
            end
        end
    end

    assign o_rd_tag   = r_tag[i_rd_index];
    assign o_rd_valid = r_valid[i_rd_index];
    assign o_rd_data  = r_data[{i_rd_index, i_rd_word}];

endmodule

// File: rtl/mem_stage_dcache.sv
// Direct-mapped write-through, no-write-allocate MEM-stage data cache with word-wide refill.
// Optional DCACHE_STATS_EN adds read_hits/read_misses/writes event counters.
module mem_stage_dcache
    import mips_mem_pkg::*;
#(
    parameter int LINES          = 16,
    parameter int WORDS_PER_LINE = 4,
    parameter int ADDR_W         = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              memRead,
    input  logic              memWrite,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WORD_W-1:0] wdata,
    output logic              hit,
    output logic [WORD_W-1:0] rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [WORD_W-1:0] mem_rdata
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0]       read_hits,
    output logic [31:0]       read_misses,
    output logic [31:0]       writes
`endif
);

    localparam int OFF_W  = offset_w(WORDS_PER_LINE);
    localparam int WOFF_W = word_off_w(WORDS_PER_LINE);
    localparam int IDX_W  = index_w(LINES);
    localparam int TAG_W  = tag_w(ADDR_W, LINES, WORDS_PER_LINE);
    localparam logic [WOFF_W-1:0] LAST_BEAT = WOFF_W'(WORDS_PER_LINE - 1);
    localparam logic [WOFF_W-1:0] ONE_BEAT  = WOFF_W'(1);

    state_e            r_state;
    state_e            w_state_nxt;
    logic [TAG_W-1:0]  r_tag;
    logic [IDX_W-1:0]  r_index;
    logic [WOFF_W-1:0] r_beat;
    logic              r_mem_req;
    logic              r_mem_we;

    logic [TAG_W-1:0]  w_tag;
    logic [IDX_W-1:0]  w_index;
    logic [WOFF_W-1:0] w_word;
    logic [TAG_W-1:0]  w_rd_tag;
    logic              w_rd_valid;
    logic [WORD_W-1:0] w_rd_data;
    logic              w_lookup_hit;
    logic              w_wr_en;
    logic [IDX_W-1:0]  w_wr_index;
    logic [WOFF_W-1:0] w_wr_word;
    logic [WORD_W-1:0] w_wr_data;
    logic              w_clr_en;
    logic              w_set_en;
    logic              w_unused_addr_lsb;

    assign w_tag             = addr[ADDR_W-1 -: TAG_W];
    assign w_index           = addr[OFF_W +: IDX_W];
    assign w_word            = addr[2 +: WOFF_W];
    assign w_lookup_hit      = w_rd_valid && (w_rd_tag == w_tag);
    assign w_unused_addr_lsb = &addr[1:0];

    dcache_line_store #(
        .LINES          (LINES),
        .WORDS_PER_LINE (WORDS_PER_LINE),
        .TAG_W          (TAG_W),
        .IDX_W          (IDX_W),
        .WOFF_W         (WOFF_W)
    ) u_store (
        .clk         (clk),
        .rst         (rst),
        .i_rd_index  (w_index),
        .i_rd_word   (w_word),
        .o_rd_tag    (w_rd_tag),
        .o_rd_valid  (w_rd_valid),
        .o_rd_data   (w_rd_data),
        .i_wr_en     (w_wr_en),
        .i_wr_index  (w_wr_index),
        .i_wr_word   (w_wr_word),
        .i_wr_data   (w_wr_data),
        .i_clr_en    (w_clr_en),
        .i_clr_index (w_index),
        .i_set_en    (w_set_en),
        .i_set_index (r_index),
        .i_set_tag   (r_tag)
    );

    // Next state, pipeline handshake and array write-port steering.
    always_comb begin
        w_state_nxt = r_state;
        hit         = 1'b0;
        rdata       = '0;
        w_wr_en     = 1'b0;
        w_wr_index  = w_index;
        w_wr_word   = w_word;
        w_wr_data   = wdata;
        w_clr_en    = 1'b0;
        w_set_en    = 1'b0;
        mem_addr    = {addr[ADDR_W-1:2], 2'b00};
        case (r_state)
            S_IDLE: begin
                if (memWrite) begin
                    w_state_nxt = S_WRITE;
                end else if (memRead) begin
                    if (w_lookup_hit) begin
                        hit   = 1'b1;
                        rdata = w_rd_data;
                    end else begin
                        w_clr_en    = 1'b1;
                        w_state_nxt = S_REFILL;
                    end
                end else begin
                    hit = 1'b1;
                end
            end
            S_REFILL: begin
                mem_addr = {r_tag, r_index, r_beat, 2'b00};
                if (mem_ready) begin
                    w_wr_en    = 1'b1;
                    w_wr_index = r_index;
                    w_wr_word  = r_beat;
                    w_wr_data  = mem_rdata;
                    if (r_beat == LAST_BEAT) begin
                        w_set_en    = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_set_en = 1'b0;
                    end
                end else begin
                    w_wr_en = 1'b0;
                end
            end
            S_WRITE: begin
                if (mem_ready) begin
                    w_wr_en     = w_lookup_hit;
                    hit         = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    hit = 1'b0;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State, captured line address, beat counter and registered bus controls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_tag     <= '0;
            r_index   <= '0;
            r_beat    <= '0;
            r_mem_req <= 1'b0;
            r_mem_we  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_mem_req <= (w_state_nxt != S_IDLE);
            r_mem_we  <= (w_state_nxt == S_WRITE);
            if (r_state == S_IDLE) begin
                r_tag   <= w_tag;
                r_index <= w_index;
                r_beat  <= '0;
            end else if (r_state == S_REFILL && mem_ready) begin
                r_beat <= r_beat + ONE_BEAT;
            end else begin
                r_beat <= r_beat;
            end
        end
    end

    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_wdata = wdata;

`ifdef DCACHE_STATS_EN
    logic        r_refilled;
    logic [31:0] r_read_hits;
    logic [31:0] r_read_misses;
    logic [31:0] r_writes;

    // Access counters; r_refilled marks the re-lookup that follows a refill.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_refilled    <= 1'b0;
            r_read_hits   <= 32'd0;
            r_read_misses <= 32'd0;
            r_writes      <= 32'd0;
        end else begin
            r_refilled <= (r_state == S_REFILL) && (w_state_nxt == S_IDLE);
            if (r_state == S_IDLE && memRead && !memWrite && w_lookup_hit && !r_refilled) begin
                r_read_hits <= r_read_hits + 32'd1;
            end
            if (r_state == S_IDLE && w_state_nxt == S_REFILL) begin
                r_read_misses <= r_read_misses + 32'd1;
            end
            if (r_state == S_WRITE && mem_ready) begin
                r_writes <= r_writes + 32'd1;
            end
        end
    end

    assign read_hits   = r_read_hits;
    assign read_misses = r_read_misses;
    assign writes      = r_writes;
`endif

endmodule

// File: tb/tb_mem_stage_dcache.sv
// Self-checking bench for mem_stage_dcache: directed vector table, reset-mid-refill sequence,
// and randomized accesses checked against a line-level cache/memory reference model.
module tb_mem_stage_dcache;

    logic        clk;
    logic        rst;
    logic        memRead;
    logic        memWrite;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        hit;
    logic [31:0] rdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    int n_checks = 0;
    int n_err    = 0;

    mem_stage_dcache dut (
        .clk       (clk),
        .rst       (rst),
        .memRead   (memRead),
        .memWrite  (memWrite),
        .addr      (addr),
        .wdata     (wdata),
        .hit       (hit),
        .rdata     (rdata),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Backing memory, word addressed by byte address with [1:0]=0.
    logic [31:0] mem [logic [31:0]];

    function automatic logic [31:0] mem_get(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return a ^ 32'h9E37_79B9;
    endfunction

    // Reference cache: 16 lines x 4 words, tag = a[31:8], index = a[7:4], word = a[3:2].
    bit          m_valid [16];
    logic [23:0] m_tag   [16];
    logic [31:0] m_data  [16][4];

    function automatic void model_reset();
        for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
    endfunction

    function automatic void model_read(input logic [31:0] a, input int rw,
                                       output int lat, output logic [31:0] d);
        int idx = int'(a[7:4]);
        if (m_valid[idx] && m_tag[idx] == a[31:8]) begin
            lat = 0;
        end else begin
            lat = 1 + 4 * (rw + 1);
            for (int w = 0; w < 4; w++) m_data[idx][w] = mem_get({a[31:4], 4'h0} + 32'(4 * w));
            m_tag[idx]   = a[31:8];
            m_valid[idx] = 1'b1;
        end
        d = m_data[idx][a[3:2]];
    endfunction

    function automatic void model_write(input logic [31:0] a, input logic [31:0] d,
                                        input int rw, output int lat);
        int idx = int'(a[7:4]);
        lat = 1 + rw;
        if (m_valid[idx] && m_tag[idx] == a[31:8]) m_data[idx][a[3:2]] = d;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Present one request at a negedge and act as memory until hit; returns stall cycles and rdata.
    task automatic access(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d,
                          input int rw, output int lat, output logic [31:0] rd_out);
        int wait_cnt = 0;
        int beats    = 0;
        bit done     = 1'b0;
        memRead  = rd;
        memWrite = wr;
        addr     = a;
        wdata    = d;
        lat      = 0;
        rd_out   = '0;
        for (int c = 0; c < 64 && !done; c++) begin
            mem_ready = mem_req && (wait_cnt >= rw);
            mem_rdata = (mem_ready && !mem_we) ? mem_get(mem_addr) : 32'h0;
            #1;
            if (mem_req && mem_ready) begin
                if (wr) begin
                    check("write_beat_we", {31'd0, mem_we}, 32'd1);
                    check("write_beat_addr", mem_addr, {a[31:2], 2'b00});
                    check("write_beat_data", mem_wdata, d);
                    mem[{a[31:2], 2'b00}] = d;
                end else begin
                    check("refill_beat_we", {31'd0, mem_we}, 32'd0);
                    check("refill_beat_addr", mem_addr, {a[31:4], 4'h0} + 32'(4 * beats));
                    beats++;
                end
                wait_cnt = 0;
            end else if (mem_req) begin
                wait_cnt++;
            end
            if (hit) begin
                done   = 1'b1;
                rd_out = rdata;
            end else begin
                lat++;
            end
            @(negedge clk);
        end
        if (!done) check("access_timeout", 32'd0, 32'd1);
        memRead   = 1'b0;
        memWrite  = 1'b0;
        mem_ready = 1'b0;
    endtask

    typedef struct {
        bit          rd;
        bit          wr;
        logic [31:0] a;
        logic [31:0] d;
        int          rw;
        int          exp_lat;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[$];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          lat;
        int          exp_lat;
        logic [31:0] got;
        logic [31:0] exp_d;

        for (int w = 0; w < 4; w++) begin
            mem[32'h40  + 32'(4 * w)] = 32'h0000_00A0 + 32'(w);
            mem[32'h140 + 32'(4 * w)] = 32'h0000_00B0 + 32'(w);
        end

        vecs.push_back('{1'b1, 1'b0, 32'h0000_0040, 32'h0,          0, 5, 32'h0000_00A0});
        vecs.push_back('{1'b1, 1'b0, 32'h0000_0048, 32'h0,          0, 0, 32'h0000_00A2});
        vecs.push_back('{1'b0, 1'b1, 32'h0000_0044, 32'hDEAD_BEEF,  2, 3, 32'h0});
        vecs.push_back('{1'b1, 1'b0, 32'h0000_0044, 32'h0,          0, 0, 32'hDEAD_BEEF});
        vecs.push_back('{1'b0, 1'b1, 32'h0000_1000, 32'h1234_5678,  0, 1, 32'h0});
        vecs.push_back('{1'b1, 1'b0, 32'h0000_1000, 32'h0,          0, 5, 32'h1234_5678});
        vecs.push_back('{1'b1, 1'b0, 32'h0000_0040, 32'h0,          0, 0, 32'h0000_00A0});
        vecs.push_back('{1'b1, 1'b0, 32'h0000_0140, 32'h0,          0, 5, 32'h0000_00B0});
        vecs.push_back('{1'b1, 1'b0, 32'h0000_0043, 32'h0,          1, 9, 32'h0000_00A0});
        vecs.push_back('{1'b1, 1'b0, 32'h0000_0044, 32'h0,          0, 0, 32'hDEAD_BEEF});
        vecs.push_back('{1'b1, 1'b1, 32'h0000_004C, 32'hCAFE_F00D,  1, 2, 32'h0});
        vecs.push_back('{1'b1, 1'b0, 32'h0000_004C, 32'h0,          0, 0, 32'hCAFE_F00D});
        vecs.push_back('{1'b1, 1'b0, 32'h0000_1004, 32'h0,          0, 0, 32'h0000_1004 ^ 32'h9E37_79B9});

        rst = 1'b1; memRead = 1'b0; memWrite = 1'b0; addr = '0; wdata = '0;
        mem_ready = 1'b0; mem_rdata = '0;
        @(negedge clk); #1;
        check("reset_hit", {31'd0, hit}, 32'd1);
        check("reset_mem_req", {31'd0, mem_req}, 32'd0);
        check("reset_mem_we", {31'd0, mem_we}, 32'd0);
        check("reset_rdata", rdata, 32'd0);
        @(negedge clk); rst = 1'b0;
        @(negedge clk); #1;
        check("idle_hit", {31'd0, hit}, 32'd1);
        check("idle_mem_req", {31'd0, mem_req}, 32'd0);
        check("idle_rdata", rdata, 32'd0);
        @(negedge clk);

        foreach (vecs[i]) begin
            access(vecs[i].rd, vecs[i].wr, vecs[i].a, vecs[i].d, vecs[i].rw, lat, got);
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
            if (vecs[i].rd && !vecs[i].wr) check($sformatf("vec%0d_rdata", i), got, vecs[i].exp_rdata);
        end

        // Reset two beats into a refill of 0x140 (line 4 currently holds 0x40).
        memRead = 1'b1; addr = 32'h0000_0140;
        #1;
        check("midrst_miss_stall", {31'd0, hit}, 32'd0);
        @(negedge clk);
        for (int b = 0; b < 2; b++) begin
            mem_ready = mem_req;
            mem_rdata = mem_get(mem_addr);
            #1;
            check("midrst_beat_addr", mem_addr, 32'h0000_0140 + 32'(4 * b));
            @(negedge clk);
        end
        rst = 1'b1; memRead = 1'b0; mem_ready = 1'b0;
        #1;
        check("midrst_req_drop", {31'd0, mem_req}, 32'd0);
        check("midrst_hit", {31'd0, hit}, 32'd1);
        @(negedge clk); rst = 1'b0;
        model_reset();
        @(negedge clk);
        model_read(32'h0000_0040, 0, exp_lat, exp_d);
        access(1'b1, 1'b0, 32'h0000_0040, 32'h0, 0, lat, got);
        check("postrst_reload_latency", 32'(lat), 32'(exp_lat));
        check("postrst_reload_rdata", got, exp_d);

        for (int i = 0; i < 300; i++) begin
            int          op = $urandom_range(0, 3);
            int          rw = $urandom_range(0, 2);
            logic [31:0] a  = {22'd0, 2'($urandom_range(0, 3)), 2'd0, 2'($urandom_range(0, 3)),
                               2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
            logic [31:0] d  = $urandom;
            if (i % 7 == 6) a = a | 32'h0001_0000;
            case (op)
                0: begin
                    #1;
                    check("rand_idle_hit", {31'd0, hit}, 32'd1);
                    check("rand_idle_req", {31'd0, mem_req}, 32'd0);
                    @(negedge clk);
                end
                1: begin
                    model_read(a, rw, exp_lat, exp_d);
                    access(1'b1, 1'b0, a, d, rw, lat, got);
                    check("rand_read_latency", 32'(lat), 32'(exp_lat));
                    check("rand_read_rdata", got, exp_d);
                end
                default: begin
                    model_write(a, d, rw, exp_lat);
                    access(op == 3, 1'b1, a, d, rw, lat, got);
                    check("rand_write_latency", 32'(lat), 32'(exp_lat));
                end
            endcase
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
